// File: rtl/reorder_buffer_mp.sv
// Reorder buffer with two writeback ports, two operand lookups and branch-mask squash.
// Optional macro ROB_DUAL_COMMIT_EN enables a second in-order commit lane (com1_*).
module reorder_buffer_mp #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned BR_W   = 4,
  localparam int unsigned TAG_W = $clog2(DEPTH),
  localparam int unsigned BI_W  = $clog2(BR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [REG_W-1:0]  disp_rd,
  input  logic [BR_W-1:0]   disp_br_mask,
  output logic              disp_ready,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              wb0_valid,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [TAG_W-1:0]  rd_tag_a,
  output logic              rd_hit_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [TAG_W-1:0]  rd_tag_b,
  output logic              rd_hit_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              br_valid,
  input  logic [BI_W-1:0]   br_idx,
  input  logic              br_mispredict,
  output logic              com0_valid,
  output logic [REG_W-1:0]  com0_rd,
  output logic [DATA_W-1:0] com0_data,
  output logic [TAG_W-1:0]  com0_tag,
  output logic              com1_valid,
  output logic [REG_W-1:0]  com1_rd,
  output logic [DATA_W-1:0] com1_data,
  output logic [TAG_W-1:0]  com1_tag,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] Full = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] One  = (TAG_W+1)'(1);

  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [REG_W-1:0]  rd_d   [DEPTH];
  logic [BR_W-1:0]   mask_q [DEPTH];
  logic [BR_W-1:0]   mask_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              com0_valid_q, com0_valid_d;
  logic [REG_W-1:0]  com0_rd_q, com0_rd_d;
  logic [DATA_W-1:0] com0_data_q, com0_data_d;
  logic [TAG_W-1:0]  com0_tag_q, com0_tag_d;

  logic              mispredict, disp_fire, elig0;
  logic [BR_W-1:0]   clr_bit, eff_mask0;
  logic [DEPTH-1:0]  sq;
  logic [TAG_W:0]    nsq, ncommit;
  logic              sq_found;
  logic [TAG_W-1:0]  sq_oldest, sq_idx;

  assign mispredict = br_valid && br_mispredict;
  assign clr_bit    = (br_valid && !br_mispredict) ? (BR_W'(1) << br_idx) : '0;
  assign disp_ready = (count_q < Full) && !mispredict;
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_tag   = tail_q;
  assign count      = count_q;

  // Walk from head in age order: the oldest entry carrying the mispredicted bit
  // and everything younger than it is squashed.
  always_comb begin
    sq        = '0;
    nsq       = '0;
    sq_found  = 1'b0;
    sq_oldest = tail_q;
    sq_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sq_idx = head_q + TAG_W'(k);
      if (mispredict && valid_q[sq_idx] && mask_q[sq_idx][br_idx] && !sq_found) begin
        sq_found  = 1'b1;
        sq_oldest = sq_idx;
      end
      if (sq_found && valid_q[sq_idx]) begin
        sq[sq_idx] = 1'b1;
        nsq        = nsq + One;
      end
    end
  end

  assign eff_mask0 = mask_q[head_q] & ~clr_bit;
  assign elig0     = (count_q != '0) && valid_q[head_q] && done_q[head_q] &&
                     (eff_mask0 == '0) && !sq[head_q];

`ifdef ROB_DUAL_COMMIT_EN
  logic [TAG_W-1:0]  head1;
  logic [BR_W-1:0]   eff_mask1;
  logic              elig1;
  logic              com1_valid_q, com1_valid_d;
  logic [REG_W-1:0]  com1_rd_q, com1_rd_d;
  logic [DATA_W-1:0] com1_data_q, com1_data_d;
  logic [TAG_W-1:0]  com1_tag_q, com1_tag_d;

  assign head1     = head_q + TAG_W'(1);
  assign eff_mask1 = mask_q[head1] & ~clr_bit;
  assign elig1     = elig0 && (count_q >= (TAG_W+1)'(2)) && valid_q[head1] && done_q[head1] &&
                     (eff_mask1 == '0) && !sq[head1];
  assign ncommit   = (TAG_W+1)'(elig0) + (TAG_W+1)'(elig1);

  always_comb begin
    com1_valid_d = elig1;
    com1_rd_d    = elig1 ? rd_q[head1] : '0;
    com1_data_d  = elig1 ? data_q[head1] : '0;
    com1_tag_d   = elig1 ? head1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      com1_valid_q <= 1'b0;
      com1_rd_q    <= '0;
      com1_data_q  <= '0;
      com1_tag_q   <= '0;
    end else begin
      com1_valid_q <= com1_valid_d;
      com1_rd_q    <= com1_rd_d;
      com1_data_q  <= com1_data_d;
      com1_tag_q   <= com1_tag_d;
    end
  end

  assign com1_valid = com1_valid_q;
  assign com1_rd    = com1_rd_q;
  assign com1_data  = com1_data_q;
  assign com1_tag   = com1_tag_q;
`else
  assign ncommit    = (TAG_W+1)'(elig0);
  assign com1_valid = 1'b0;
  assign com1_rd    = '0;
  assign com1_data  = '0;
  assign com1_tag   = '0;
`endif

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      mask_d[i] = mask_q[i] & ~clr_bit;
      if (sq[i]) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
    end
    // wb1 first so that wb0 overrides it on a shared tag.
    if (wb1_valid && valid_q[wb1_tag] && !sq[wb1_tag]) begin
      done_d[wb1_tag] = 1'b1;
      data_d[wb1_tag] = wb1_data;
    end
    if (wb0_valid && valid_q[wb0_tag] && !sq[wb0_tag]) begin
      done_d[wb0_tag] = 1'b1;
      data_d[wb0_tag] = wb0_data;
    end
    if (elig0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
`ifdef ROB_DUAL_COMMIT_EN
    if (elig1) begin
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end
`endif
    if (disp_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      rd_d[tail_q]    = disp_rd;
      mask_d[tail_q]  = disp_br_mask & ~clr_bit;
    end
    tail_d  = sq_found ? sq_oldest : tail_q + TAG_W'(disp_fire);
    head_d  = head_q + ncommit[TAG_W-1:0];
    count_d = count_q + (TAG_W+1)'(disp_fire) - ncommit - nsq;
  end

  always_comb begin
    com0_valid_d = elig0;
    com0_rd_d    = elig0 ? rd_q[head_q] : '0;
    com0_data_d  = elig0 ? data_q[head_q] : '0;
    com0_tag_d   = elig0 ? head_q : '0;
  end

  // Operand lookup: writeback bypass beats stored results.
  always_comb begin
    rd_hit_a  = 1'b0;
    rd_data_a = '0;
    if (wb0_valid && wb0_tag == rd_tag_a) begin
      rd_hit_a  = 1'b1;
      rd_data_a = wb0_data;
    end else if (wb1_valid && wb1_tag == rd_tag_a) begin
      rd_hit_a  = 1'b1;
      rd_data_a = wb1_data;
    end else if (valid_q[rd_tag_a] && done_q[rd_tag_a]) begin
      rd_hit_a  = 1'b1;
      rd_data_a = data_q[rd_tag_a];
    end
  end

  always_comb begin
    rd_hit_b  = 1'b0;
    rd_data_b = '0;
    if (wb0_valid && wb0_tag == rd_tag_b) begin
      rd_hit_b  = 1'b1;
      rd_data_b = wb0_data;
    end else if (wb1_valid && wb1_tag == rd_tag_b) begin
      rd_hit_b  = 1'b1;
      rd_data_b = wb1_data;
    end else if (valid_q[rd_tag_b] && done_q[rd_tag_b]) begin
      rd_hit_b  = 1'b1;
      rd_data_b = data_q[rd_tag_b];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      com0_valid_q <= 1'b0;
      com0_rd_q    <= '0;
      com0_data_q  <= '0;
      com0_tag_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      com0_valid_q <= com0_valid_d;
      com0_rd_q    <= com0_rd_d;
      com0_data_q  <= com0_data_d;
      com0_tag_q   <= com0_tag_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        mask_q[i] <= mask_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign com0_valid = com0_valid_q;
  assign com0_rd    = com0_rd_q;
  assign com0_data  = com0_data_q;
  assign com0_tag   = com0_tag_q;

endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed self-checking bench for reorder_buffer_mp (default parameters).
module tb_reorder_buffer_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_valid = 1'b0;
  logic [4:0]  disp_rd = '0;
  logic [3:0]  disp_br_mask = '0;
  logic        disp_ready;
  logic [3:0]  disp_tag;
  logic        wb0_valid = 1'b0;
  logic [3:0]  wb0_tag = '0;
  logic [31:0] wb0_data = '0;
  logic        wb1_valid = 1'b0;
  logic [3:0]  wb1_tag = '0;
  logic [31:0] wb1_data = '0;
  logic [3:0]  rd_tag_a = '0;
  logic        rd_hit_a;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_tag_b = '0;
  logic        rd_hit_b;
  logic [31:0] rd_data_b;
  logic        br_valid = 1'b0;
  logic [1:0]  br_idx = '0;
  logic        br_mispredict = 1'b0;
  logic        com0_valid;
  logic [4:0]  com0_rd;
  logic [31:0] com0_data;
  logic [3:0]  com0_tag;
  logic        com1_valid;
  logic [4:0]  com1_rd;
  logic [31:0] com1_data;
  logic [3:0]  com1_tag;
  logic [4:0]  count;

  int checks = 0;
  int passed = 0;

  reorder_buffer_mp dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_br_mask(disp_br_mask),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .rd_tag_a(rd_tag_a), .rd_hit_a(rd_hit_a), .rd_data_a(rd_data_a),
    .rd_tag_b(rd_tag_b), .rd_hit_b(rd_hit_b), .rd_data_b(rd_data_b),
    .br_valid(br_valid), .br_idx(br_idx), .br_mispredict(br_mispredict),
    .com0_valid(com0_valid), .com0_rd(com0_rd), .com0_data(com0_data), .com0_tag(com0_tag),
    .com1_valid(com1_valid), .com1_rd(com1_rd), .com1_data(com1_data), .com1_tag(com1_tag),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_rd = '0; disp_br_mask = '0;
    wb0_valid = 1'b0; wb0_tag = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_tag = '0; wb1_data = '0;
    br_valid = 1'b0; br_idx = '0; br_mispredict = 1'b0;
    rd_tag_a = '0; rd_tag_b = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    checks++; if (com0_valid !== 1'b0) $display("FAIL reset_com0: got %b want 0", com0_valid); else passed++;
    checks++; if (com1_valid !== 1'b0) $display("FAIL reset_com1: got %b want 0", com1_valid); else passed++;
    checks++; if (disp_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", disp_ready); else passed++;
    checks++; if (disp_tag !== 4'd0) $display("FAIL reset_tag: got %0d want 0", disp_tag); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp_valid = 1'b1;
      disp_rd = 5'(i + 1);
      checks++;
      if (disp_tag !== 4'(i)) $display("FAIL fill_tag%0d: got %0d want %0d", i, disp_tag, i);
      else passed++;
      tick();
    end
    checks++; if (count !== 5'd16) $display("FAIL fill_count: got %0d want 16", count); else passed++;
    checks++; if (disp_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", disp_ready); else passed++;
    checks++; if (disp_tag !== 4'd0) $display("FAIL fill_tail: got %0d want 0", disp_tag); else passed++;
    idle();
    tick();
    checks++; if (com0_valid !== 1'b0) $display("FAIL fill_nocommit: got %b want 0", com0_valid); else passed++;
    checks++; if (count !== 5'd16) $display("FAIL fill_hold: got %0d want 16", count); else passed++;
  endtask

  task automatic test_wb_commit();
    do_reset();
    disp_valid = 1'b1; disp_rd = 5'd3;
    tick();
    idle();
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'hDEADBEEF; rd_tag_a = 4'd0;
    #1;
    checks++; if (rd_hit_a !== 1'b1 || rd_data_a !== 32'hDEADBEEF)
      $display("FAIL wb_bypass: got %b/%h want 1/deadbeef", rd_hit_a, rd_data_a); else passed++;
    tick();
    idle();
    rd_tag_b = 4'd0;
    #1;
    checks++; if (com0_valid !== 1'b0) $display("FAIL lat_n1: got %b want 0", com0_valid); else passed++;
    checks++; if (rd_hit_b !== 1'b1 || rd_data_b !== 32'hDEADBEEF)
      $display("FAIL lookup_stored: got %b/%h want 1/deadbeef", rd_hit_b, rd_data_b); else passed++;
    tick();
    checks++; if (com0_valid !== 1'b1) $display("FAIL lat_n2: got %b want 1", com0_valid); else passed++;
    checks++; if (com0_data !== 32'hDEADBEEF) $display("FAIL com_data: got %h want deadbeef", com0_data); else passed++;
    checks++; if (com0_tag !== 4'd0 || com0_rd !== 5'd3)
      $display("FAIL com_tag_rd: got %0d/%0d want 0/3", com0_tag, com0_rd); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL com_count: got %0d want 0", count); else passed++;
    tick();
    checks++; if (com0_valid !== 1'b0 || com0_data !== 32'd0)
      $display("FAIL com_pulse: got %b/%h want 0/0", com0_valid, com0_data); else passed++;
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp_valid = 1'b1;
      disp_rd = 5'(i + 10);
      disp_br_mask = (i == 1 || i == 2) ? 4'b0001 : 4'b0000;
      tick();
    end
    idle();
    br_valid = 1'b1; br_idx = 2'd0; br_mispredict = 1'b1;
    disp_valid = 1'b1; disp_rd = 5'd9;
    #1;
    checks++; if (disp_ready !== 1'b0) $display("FAIL mp_ready: got %b want 0", disp_ready); else passed++;
    tick();
    idle();
    checks++; if (count !== 5'd1) $display("FAIL mp_count: got %0d want 1", count); else passed++;
    checks++; if (disp_tag !== 4'd1) $display("FAIL mp_tail: got %0d want 1", disp_tag); else passed++;
    wb0_valid = 1'b1; wb0_tag = 4'd2; wb0_data = 32'h22;
    wb1_valid = 1'b1; wb1_tag = 4'd3; wb1_data = 32'h33;
    tick();
    idle();
    rd_tag_a = 4'd3; rd_tag_b = 4'd2;
    #1;
    checks++; if (rd_hit_a !== 1'b0) $display("FAIL mp_inval3: got %b want 0", rd_hit_a); else passed++;
    checks++; if (rd_hit_b !== 1'b0) $display("FAIL mp_inval2: got %b want 0", rd_hit_b); else passed++;
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'h10;
    tick();
    idle();
    tick();
    checks++; if (com0_valid !== 1'b1 || com0_tag !== 4'd0 || com0_rd !== 5'd10)
      $display("FAIL mp_survivor: got %b/%0d/%0d want 1/0/10", com0_valid, com0_tag, com0_rd);
    else passed++;
    checks++; if (count !== 5'd0) $display("FAIL mp_drain: got %0d want 0", count); else passed++;
  endtask

  task automatic test_resolve();
    do_reset();
    disp_valid = 1'b1; disp_rd = 5'd7; disp_br_mask = 4'b0010;
    tick();
    idle();
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'h55;
    tick();
    idle();
    tick();
    checks++; if (com0_valid !== 1'b0) $display("FAIL res_blocked: got %b want 0", com0_valid); else passed++;
    br_valid = 1'b1; br_idx = 2'd1; br_mispredict = 1'b0;
    disp_valid = 1'b1; disp_rd = 5'd8; disp_br_mask = 4'b0010;
    #1;
    checks++; if (disp_ready !== 1'b1) $display("FAIL res_ready: got %b want 1", disp_ready); else passed++;
    tick();
    idle();
    checks++; if (com0_valid !== 1'b1 || com0_rd !== 5'd7 || com0_data !== 32'h55)
      $display("FAIL res_commit: got %b/%0d/%h want 1/7/55", com0_valid, com0_rd, com0_data);
    else passed++;
    checks++; if (count !== 5'd1) $display("FAIL res_count: got %0d want 1", count); else passed++;
    wb0_valid = 1'b1; wb0_tag = 4'd1; wb0_data = 32'h66;
    tick();
    idle();
    tick();
    checks++; if (com0_valid !== 1'b1 || com0_tag !== 4'd1 || com0_data !== 32'h66)
      $display("FAIL res_samecyc: got %b/%0d/%h want 1/1/66", com0_valid, com0_tag, com0_data);
    else passed++;
  endtask

  task automatic test_dual_wb();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      disp_valid = 1'b1; disp_rd = 5'(i);
      tick();
    end
    idle();
    wb0_valid = 1'b1; wb0_tag = 4'd5; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_tag = 4'd5; wb1_data = 32'h22;
    rd_tag_a = 4'd5; rd_tag_b = 4'd4;
    #1;
    checks++; if (rd_hit_a !== 1'b1 || rd_data_a !== 32'h11)
      $display("FAIL dwb_bypass: got %b/%h want 1/11", rd_hit_a, rd_data_a); else passed++;
    checks++; if (rd_hit_b !== 1'b0 || rd_data_b !== 32'h0)
      $display("FAIL dwb_miss: got %b/%h want 0/0", rd_hit_b, rd_data_b); else passed++;
    tick();
    idle();
    rd_tag_a = 4'd5;
    wb1_valid = 1'b1; wb1_tag = 4'd4; wb1_data = 32'h44; rd_tag_b = 4'd4;
    #1;
    checks++; if (rd_hit_a !== 1'b1 || rd_data_a !== 32'h11)
      $display("FAIL dwb_stored: got %b/%h want 1/11", rd_hit_a, rd_data_a); else passed++;
    checks++; if (rd_hit_b !== 1'b1 || rd_data_b !== 32'h44)
      $display("FAIL wb1_bypass: got %b/%h want 1/44", rd_hit_b, rd_data_b); else passed++;
    tick();
    idle();
  endtask

  task automatic test_commit_order();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      disp_valid = 1'b1; disp_rd = 5'(i + 20);
      tick();
    end
    idle();
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'hA0;
    wb1_valid = 1'b1; wb1_tag = 4'd1; wb1_data = 32'hA1;
    tick();
    idle();
    tick();
    checks++; if (com0_valid !== 1'b1 || com0_tag !== 4'd0 || com0_data !== 32'hA0)
      $display("FAIL ord_first: got %b/%0d/%h want 1/0/a0", com0_valid, com0_tag, com0_data);
    else passed++;
`ifdef ROB_DUAL_COMMIT_EN
    checks++; if (com1_valid !== 1'b1 || com1_tag !== 4'd1 || com1_data !== 32'hA1)
      $display("FAIL dual_com1: got %b/%0d/%h want 1/1/a1", com1_valid, com1_tag, com1_data);
    else passed++;
    checks++; if (count !== 5'd0) $display("FAIL dual_count: got %0d want 0", count); else passed++;
`else
    checks++; if (com1_valid !== 1'b0) $display("FAIL single_com1: got %b want 0", com1_valid); else passed++;
    checks++; if (count !== 5'd1) $display("FAIL single_count: got %0d want 1", count); else passed++;
    tick();
    checks++; if (com0_valid !== 1'b1 || com0_tag !== 4'd1 || com0_data !== 32'hA1)
      $display("FAIL ord_second: got %b/%0d/%h want 1/1/a1", com0_valid, com0_tag, com0_data);
    else passed++;
    checks++; if (count !== 5'd0) $display("FAIL ord_count: got %0d want 0", count); else passed++;
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp_valid = 1'b1; disp_rd = 5'(i + 1);
      tick();
    end
    idle();
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'h77;
    tick();
    idle();
    disp_valid = 1'b1; disp_rd = 5'd20;
    #1;
    checks++; if (disp_ready !== 1'b0) $display("FAIL wrap_full_ready: got %b want 0", disp_ready); else passed++;
    tick();
    checks++; if (com0_valid !== 1'b1 || com0_tag !== 4'd0)
      $display("FAIL wrap_commit: got %b/%0d want 1/0", com0_valid, com0_tag); else passed++;
    checks++; if (count !== 5'd15) $display("FAIL wrap_c15: got %0d want 15", count); else passed++;
    checks++; if (disp_ready !== 1'b1 || disp_tag !== 4'd0)
      $display("FAIL wrap_tag: got %b/%0d want 1/0", disp_ready, disp_tag); else passed++;
    tick();
    idle();
    rd_tag_a = 4'd0;
    #1;
    checks++; if (count !== 5'd16) $display("FAIL wrap_c16: got %0d want 16", count); else passed++;
    checks++; if (disp_tag !== 4'd1) $display("FAIL wrap_tail: got %0d want 1", disp_tag); else passed++;
    checks++; if (rd_hit_a !== 1'b0) $display("FAIL wrap_newentry: got %b want 0", rd_hit_a); else passed++;
    checks++; if (com0_valid !== 1'b0) $display("FAIL wrap_nocommit: got %b want 0", com0_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1'b1; disp_rd = 5'(i + 1);
      tick();
    end
    idle();
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'h99;
    tick();
    idle();
    tick();
    checks++; if (com0_valid !== 1'b1) $display("FAIL rmid_pre: got %b want 1", com0_valid); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (com0_valid !== 1'b0 || com0_data !== 32'd0)
      $display("FAIL rmid_com: got %b/%h want 0/0", com0_valid, com0_data); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL rmid_count: got %0d want 0", count); else passed++;
    rst = 1'b1;
    disp_valid = 1'b1; disp_rd = 5'd4;
    #1;
    checks++; if (disp_tag !== 4'd0) $display("FAIL rmid_tag: got %0d want 0", disp_tag); else passed++;
    tick();
    idle();
    checks++; if (count !== 5'd1 || disp_tag !== 4'd1)
      $display("FAIL rmid_disp: got %0d/%0d want 1/1", count, disp_tag); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wb_commit();
    test_mispredict();
    test_resolve();
    test_dual_wb();
    test_commit_order();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_mp.md
REORDER_BUFFER_MP -- requirements
Module: reorder_buffer_mp

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count; power of two, >= 4.
REQ-002 SHALL have parameter DATA_W, default 32: result width.
REQ-003 SHALL have parameter REG_W, default 5: destination register index width.
REQ-004 SHALL have parameter BR_W, default 4: branch-mask width; TAG_W = log2(DEPTH), BI_W = log2(BR_W).
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports disp_valid in 1, disp_rd in REG_W, disp_br_mask in BR_W, disp_ready out 1, disp_tag out TAG_W: dispatch handshake; disp_tag = tail index.
REQ-008 SHALL have ports wb0_valid in 1, wb0_tag in TAG_W, wb0_data in DATA_W, plus identical wb1_*: two writeback ports (ALU, LS).
REQ-009 SHALL have ports rd_tag_a in TAG_W, rd_hit_a out 1, rd_data_a out DATA_W, plus identical *_b: operand lookup.
REQ-010 SHALL have ports br_valid in 1, br_idx in BI_W, br_mispredict in 1: branch resolution.
REQ-011 SHALL have ports com0_valid out 1, com0_rd out REG_W, com0_data out DATA_W, com0_tag out TAG_W, plus identical com1_*: registered commit.
REQ-012 SHALL have port count out TAG_W+1: registered occupancy.

Function
REQ-013 disp_ready SHALL be (count < DEPTH) and not (br_valid and br_mispredict); dispatch accepted when disp_valid and disp_ready.
REQ-014 Accepted dispatch SHALL write entry at tail (valid=1, done=0, rd, mask); tail increments modulo DEPTH.
REQ-015 Dispatched mask SHALL have bit br_idx cleared if a correct resolution occurs in the same cycle.
REQ-016 Writeback to a valid entry SHALL set done and store data; writeback to an invalid entry SHALL be ignored; both ports on one tag: wb0 wins.
REQ-017 Lookup SHALL be combinational, priority wb0 match, wb1 match, stored valid-and-done entry; otherwise rd_hit=0, rd_data=0.
REQ-018 Correct resolution SHALL clear bit br_idx in every entry mask in one cycle.
REQ-019 Mispredict SHALL invalidate every entry with bit br_idx set, move tail back to the oldest invalidated index, and reduce count accordingly, in one cycle.
REQ-020 Head entry SHALL be commit-eligible when valid, done and its mask, after this cycle's resolution, is zero and not squashed.
REQ-021 Eligible head SHALL drive com0_* at next edge, com0_valid high one cycle; head increments modulo DEPTH; otherwise com0_valid=0, com0_* = 0.
REQ-022 Latency: writeback in cycle N to the head entry with zero mask SHALL produce com0_valid in cycle N+2.
REQ-023 count SHALL update as count + accepted dispatch - commits - squashed; dispatch and commit in one cycle SHALL leave count unchanged.
REQ-024 Empty (count=0): no commit; full (count=DEPTH): disp_ready=0 even if commit occurs that cycle.

Reset
REQ-025 rst low SHALL immediately clear head, tail, count, all valid/done bits, and all com*_ outputs to 0, independent of clk.
REQ-026 Reset mid-operation SHALL discard all in-flight entries; first dispatch after release gets disp_tag 0.

Configuration
REQ-027 Macro ROB_DUAL_COMMIT_EN defined: second-oldest entry SHALL commit on com1_* in the same cycle when head and head+1 are both eligible; head advances by 2.
REQ-028 Macro undefined: com1_valid and all com1_* SHALL be tied to 0; at most one commit per cycle.

Verification
REQ-029 Reset, dispatch 16 entries rd=1..16, no writeback -> count=16, disp_ready=0, disp_tag=0.
REQ-030 Dispatch tag 0, wb0 tag 0 data 0xDEADBEEF in cycle N -> com0_valid=1, com0_data=0xDEADBEEF, com0_tag=0 in cycle N+2.
REQ-031 Dispatch tags 0-3 masks 0,1,1,0, br_valid idx 0 mispredict -> tags 1-3 invalid, tail=1, count=1.
REQ-032 Same cycle wb0 and wb1 on tag 5 with 0x11/0x22, lookup tag 5 -> rd_hit=1, rd_data=0x11; stored 0x11.
REQ-033 With ROB_DUAL_COMMIT_EN, tags 0,1 done with zero masks -> com0_tag=0, com1_tag=1 same cycle, count drops by 2; without macro, commits in consecutive cycles.
REQ-034 Full buffer, wrap: commit one, dispatch one -> new entry tag 0 after tag 15, count remains 16.
